// File: rtl/sum_collect_pkg.sv
// Shared defaults and width helpers for the sum-collecting FIFO.
// The widths follow from DEPTH so that the top and storage agree on pointer size.
package sum_collect_pkg;

    localparam int W_DEF     = 12;
    localparam int DEPTH_DEF = 4;
    localparam int ACC_W_DEF = W_DEF + 4;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

    localparam int PTR_W_DEF = ptr_width(DEPTH_DEF);
    localparam int CNT_W_DEF = cnt_width(DEPTH_DEF);

endpackage

// File: rtl/sum_collect_ram.sv
// DEPTH x W storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module sum_collect_ram
    import sum_collect_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int PTR_W = ptr_width(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [W-1:0]     wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [W-1:0]     rdata
);

    logic [W-1:0] mem_r [DEPTH];

    // Write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sum_collect_fifo.sv
// First-word-fall-through FIFO for adder sums, with a running accumulator of
// every word popped and a sticky overflow flag for dropped words.
module sum_collect_fifo
    import sum_collect_pkg::*;
#(
    parameter int W     = W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int ACC_W = W + 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [W-1:0]               in_data,
    input  logic                       clear,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [W-1:0]               out_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [ACC_W-1:0]           acc,
    output logic                       overflow
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(DEPTH);

    logic [PTR_W-1:0] wptr_r;
    logic [PTR_W-1:0] rptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;
    logic [ACC_W-1:0] acc_r;
    logic             ovf_r;
    logic             valid_r;
    logic             push_s;
    logic             pop_s;
    logic             we_s;
    logic [W-1:0]     rd_data_s;

    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign pop_s  = valid_r & out_ready;
    assign push_s = in_valid & ((count_r != CNT_W'(DEPTH)) | pop_s);
    assign we_s   = push_s & ~clear;

    // Next occupancy from the push/pop pair
    always_comb begin
        count_nxt_s = count_r;
        case ({push_s, pop_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointers, occupancy, accumulator and sticky overflow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
        end else if (clear) begin
            wptr_r  <= '0;
            rptr_r  <= '0;
            count_r <= '0;
            valid_r <= 1'b0;
            acc_r   <= '0;
            ovf_r   <= 1'b0;
        end else begin
            if (push_s) begin
                wptr_r <= wptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rptr_r <= rptr_r + PTR_W'(1);
                acc_r  <= acc_r + ACC_W'(rd_data_s);
            end
            if (in_valid && !push_s) begin
                ovf_r <= 1'b1;
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != CNT_W'(0));
        end
    end

    sum_collect_ram #(
        .W     (W),
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we_s),
        .waddr (wptr_r),
        .wdata (in_data),
        .raddr (rptr_r),
        .rdata (rd_data_s)
    );

    // Masking keeps out_data defined while the unreset storage is still unknown.
    assign out_data  = valid_r ? rd_data_s : W'(0);
    assign out_valid = valid_r;
    assign count     = count_r;
    assign acc       = acc_r;
    assign overflow  = ovf_r;

endmodule

// File: tb/tb_sum_collect_fifo.sv
// Self-checking bench for sum_collect_fifo: directed scenarios plus random
// traffic compared against a queue-based reference model.
module tb_sum_collect_fifo;

    localparam int W     = 12;
    localparam int DEPTH = 4;
    localparam int ACC_W = 16;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic [W-1:0]     in_data = '0;
    logic             clear = 1'b0;
    logic             out_ready = 1'b0;
    logic             out_valid;
    logic [W-1:0]     out_data;
    logic [CNT_W-1:0] count;
    logic [ACC_W-1:0] acc;
    logic             overflow;

    int errors = 0;
    int checks = 0;

    int               mq[$];
    logic [ACC_W-1:0] m_acc = '0;
    bit               m_ovf = 1'b0;

    sum_collect_fifo #(.W(W), .DEPTH(DEPTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .clear     (clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count),
        .acc       (acc),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic model_edge();
        bit pop;
        bit push;
        int v;
        if (rst || clear) begin
            mq.delete();
            m_acc = '0;
            m_ovf = 1'b0;
        end else begin
            pop  = (mq.size() > 0) && out_ready;
            push = in_valid && ((mq.size() < DEPTH) || pop);
            if (pop) begin
                v = mq.pop_front();
                m_acc = m_acc + ACC_W'(v);
            end
            if (push) mq.push_back(int'(in_data));
            else if (in_valid) m_ovf = 1'b1;
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] d, input logic r, input logic c);
        in_valid = v; in_data = d; out_ready = r; clear = c;
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 12'hABC, 1'b0, 1'b0);
        repeat (3) cycle();
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0 || acc !== 16'd0 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got v=%b c=%0d a=%0h o=%b want 0 0 0 0", out_valid, count, acc, overflow);
        end
        checks++;
        if (out_data !== 12'h000) begin
            errors++;
            $display("FAIL reset_out_data got=%h want=000", out_data);
        end
        drive(1'b0, 12'h000, 1'b0, 1'b0);
        rst = 1'b0;
        cycle();
    endtask

    task automatic test_single();
        drive(1'b1, 12'h123, 1'b0, 1'b0);
        cycle();
        checks++;
        if (out_valid !== 1'b1 || out_data !== 12'h123 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_push got v=%b d=%h c=%0d want 1 123 1", out_valid, out_data, count);
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd0 || acc !== 16'h0123 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_pop got c=%0d a=%h v=%b want 0 0123 0", count, acc, out_valid);
        end
        // Ready with an empty FIFO must leave everything alone.
        cycle();
        checks++;
        if (count !== 3'd0 || acc !== 16'h0123) begin
            errors++;
            $display("FAIL empty_pop got c=%0d a=%h want 0 0123", count, acc);
        end
    endtask

    task automatic test_fill_overflow();
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        cycle();
        for (int i = 1; i <= 5; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            cycle();
        end
        checks++;
        if (count !== 3'd4 || overflow !== 1'b1) begin
            errors++;
            $display("FAIL fill_overflow got c=%0d o=%b want 4 1", count, overflow);
        end
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 12'h000, 1'b1, 1'b0);
            checks++;
            if (out_data !== W'(i) || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL drain_order got=%h v=%b want=%h", out_data, out_valid, W'(i));
            end
            cycle();
        end
        checks++;
        if (acc !== 16'd10 || overflow !== 1'b1 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_final got a=%0d o=%b c=%0d want 10 1 0", acc, overflow, count);
        end
    endtask

    task automatic test_full_push_pop();
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        cycle();
        for (int i = 5; i <= 8; i++) begin
            drive(1'b1, W'(i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b1, 12'h009, 1'b1, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd4 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop got c=%0d o=%b want 4 0", count, overflow);
        end
        for (int i = 6; i <= 9; i++) begin
            drive(1'b0, 12'h000, 1'b1, 1'b0);
            checks++;
            if (out_data !== W'(i)) begin
                errors++;
                $display("FAIL full_drain got=%h want=%h", out_data, W'(i));
            end
            cycle();
        end
        // Push and pop together at count 1 keeps count at 1.
        drive(1'b1, 12'h0A1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 12'h0A2, 1'b1, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd1 || out_data !== 12'h0A2) begin
            errors++;
            $display("FAIL one_push_pop got c=%0d d=%h want 1 0A2", count, out_data);
        end
    endtask

    task automatic test_acc_wrap();
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        cycle();
        repeat (17) begin
            drive(1'b1, 12'hFFF, 1'b0, 1'b0);
            cycle();
            drive(1'b0, 12'h000, 1'b1, 1'b0);
            cycle();
        end
        checks++;
        if (acc !== 16'h0FEF || acc !== m_acc) begin
            errors++;
            $display("FAIL acc_wrap got=%h want=0FEF", acc);
        end
    endtask

    task automatic test_clear();
        drive(1'b0, 12'h000, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, W'(12'h100 + i), 1'b0, 1'b0);
            cycle();
        end
        drive(1'b0, 12'h000, 1'b1, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd3 || overflow !== 1'b1 || acc !== 16'h0100) begin
            errors++;
            $display("FAIL clear_setup got c=%0d o=%b a=%h want 3 1 0100", count, overflow, acc);
        end
        drive(1'b1, 12'h777, 1'b1, 1'b1);
        cycle();
        checks++;
        if (count !== 3'd0 || acc !== 16'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_prio got c=%0d a=%h o=%b v=%b want 0 0 0 0", count, acc, overflow, out_valid);
        end
    endtask

    task automatic test_mid_reset();
        drive(1'b1, 12'h0C1, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 12'h0C2, 1'b0, 1'b0);
        cycle();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || acc !== 16'd0) begin
            errors++;
            $display("FAIL async_reset got c=%0d v=%b a=%h want 0 0 0", count, out_valid, acc);
        end
        mq.delete(); m_acc = '0; m_ovf = 1'b0;
        cycle();
        rst = 1'b0;
        drive(1'b1, 12'h055, 1'b0, 1'b0);
        cycle();
        checks++;
        if (count !== 3'd1 || out_data !== 12'h055 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got c=%0d d=%h v=%b want 1 055 1", count, out_data, out_valid);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            drive(1'($urandom_range(0, 2) != 0), W'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 40) == 0));
            cycle();
            checks++;
            if (count !== CNT_W'(mq.size()) || out_valid !== (mq.size() != 0) ||
                acc !== m_acc || overflow !== m_ovf) begin
                errors++;
                $display("FAIL random_state n=%0d got c=%0d v=%b a=%h o=%b want c=%0d a=%h o=%b",
                         n, count, out_valid, acc, overflow, mq.size(), m_acc, m_ovf);
            end
            if (mq.size() != 0) begin
                checks++;
                if (out_data !== W'(mq[0])) begin
                    errors++;
                    $display("FAIL random_head n=%0d got=%h want=%h", n, out_data, W'(mq[0]));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_push_pop();
        test_acc_wrap();
        test_clear();
        test_mid_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sum_collect_fifo.md
SUM_COLLECT_FIFO -- requirements
Module: sum_collect_fifo

Interface
REQ-001 Parameter W, default 12, width of each incoming sum word.
REQ-002 Parameter DEPTH, default 4, number of FIFO entries; power of two, >=2.
REQ-003 Parameter ACC_W, default W+4, width of the running accumulator.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  sum word present on in_data; driven by the upstream adder's valid.
REQ-007 in_data  input  W  sum word; driven by the upstream adder's y.
REQ-008 clear  input  1  synchronous flush of FIFO, accumulator and flags.
REQ-009 out_valid  output  1  head entry available.
REQ-010 out_ready  input  1  consumer accepts the head entry.
REQ-011 out_data  output  W  head entry (first-word-fall-through).
REQ-012 count  output  $clog2(DEPTH+1)  current occupancy.
REQ-013 acc  output  ACC_W  running sum of all popped words.
REQ-014 overflow  output  1  sticky; a word was dropped because the FIFO was full.

Function
REQ-015 Push occurs on a clock edge where in_valid=1 and (count<DEPTH, or a pop occurs on the same edge).
REQ-016 Pop occurs on a clock edge where out_valid=1 and out_ready=1.
REQ-017 out_valid SHALL equal (count!=0); out_data SHALL show the oldest entry combinationally from storage, with no extra register stage.
REQ-018 Latency: a word pushed into an empty FIFO at edge N SHALL appear on out_data with out_valid=1 immediately after edge N.
REQ-019 Simultaneous push and pop SHALL leave count unchanged; this holds when count=DEPTH (no drop) and when count=1.
REQ-020 Push attempt when full without a same-edge pop: the word is dropped, count stays DEPTH, overflow set to 1.
REQ-021 overflow SHALL stay 1 until clear or rst.
REQ-022 out_ready with count=0: no effect; count stays 0, acc unchanged.
REQ-023 On every pop, acc <= acc + zero-extended out_data, modulo 2^ACC_W, with silent wrap.
REQ-024 Read/write pointers are log2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-025 clear=1 SHALL, at the next edge, set count=0, acc=0, overflow=0 and both pointers to 0; clear overrides any push or pop on the same edge.
REQ-026 Storage contents are not reset; out_data is don't-care while out_valid=0.

Reset
REQ-027 rst=1 SHALL asynchronously force count=0, pointers=0, acc=0, overflow=0, out_valid=0.
REQ-028 rst asserted mid-operation discards all entries; the first edge after rst deasserts behaves as an empty FIFO.
REQ-029 No output SHALL be X while rst=1.

Structure
REQ-030 Package sum_collect_pkg SHALL hold the W/DEPTH/ACC_W defaults and the pointer and count width constants.
REQ-031 Storage SHALL be one sub-module, sum_collect_ram: DEPTH x W, 1 write port, 1 asynchronous read port, no reset.
REQ-032 Pointer, count, accumulator and flag logic reside in sum_collect_fifo.

Verification
REQ-033 Reset: hold rst=1 for 3 cycles with in_valid=1 -> out_valid=0, count=0, acc=0, overflow=0.
REQ-034 Single pass: push 0x123 into empty FIFO with out_ready=0 -> next cycle out_valid=1, out_data=0x123, count=1; raise out_ready -> count=0, acc=0x123.
REQ-035 Fill and overflow: push 1,2,3,4,5 with out_ready=0 -> count=4, overflow=1; drain -> outputs 1,2,3,4 in order, acc=10, overflow still 1.
REQ-036 Full plus simultaneous push/pop: from full, in_valid=1 with in_data=9 and out_ready=1 -> count stays 4, overflow stays 0, 9 later emerges last.
REQ-037 Accumulator wrap: pop 0xFFF seventeen times (ACC_W=16) -> acc=0x0FEF.
REQ-038 Clear priority: with count=3, assert clear together with in_valid and out_ready -> next cycle count=0, acc=0, overflow=0, out_valid=0.
